eq_reg_bank: RTL and testbench

Register bank directly downstream of the I2C slave in the audio equalizer control path. It consumes the received byte stream (pointer byte first, then data bytes with auto-increment) and holds the equalizer control and per-band gain registers in a shadow/active pair. The active copy updates atomically when the I2C transaction ends, so the equalizer datapath never sees a half-written configuration. It also supplies the transmit byte for master reads.

---
 rtl/eq_cfg_pkg.sv | 17 +
 rtl/eq_edge_det.sv | 23 ++
 rtl/eq_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_eq_reg_bank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_cfg_pkg.sv
// Shared constants and FSM encoding for the equalizer control register bank.
package eq_cfg_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_GAIN_BASE = 8'h01;
    localparam logic [7:0] GAIN_RST       = 8'h80;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_BYP_BIT = 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitPtr = 2'd1,
        StData    = 2'd2
    } eq_state_e;

endpackage

// File: rtl/eq_edge_det.sv
// Registered rise/fall detector; pulses are valid in the cycle the input changes.
module eq_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/eq_reg_bank.sv
// Shadow/active register bank fed by the I2C slave byte stream; the active copy
// commits atomically when the bus transaction ends.
module eq_reg_bank
    import eq_cfg_pkg::*;
#(
    parameter int unsigned NUM_BANDS = 10,
    parameter logic [7:0]  GAIN_RST  = eq_cfg_pkg::GAIN_RST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_active,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_next,
    output logic [7:0]             tx_data,
    output logic                   eq_enable,
    output logic                   eq_bypass,
    output logic [8*NUM_BANDS-1:0] band_gain,
    output logic                   cfg_update,
    output logic                   addr_err
);

    localparam logic [7:0] LAST_ADDR = 8'(NUM_BANDS);

    logic bus_rise, bus_fall, rx_rise, unused_rx_fall;
    logic accept, mapped;
    logic start, commit, ptr_load, ptr_inc, wr_en;

    eq_state_e state_q, state_d;
    logic [7:0] ptr_q;
    logic       dirty_q, addr_err_q, cfg_update_q;
    logic [1:0] sh_ctrl_q, act_ctrl_q;
    logic [7:0] sh_gain_q  [NUM_BANDS];
    logic [7:0] act_gain_q [NUM_BANDS];

    eq_edge_det u_bus_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (bus_active),
        .rise  (bus_rise),
        .fall  (bus_fall)
    );

    eq_edge_det u_rx_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (rx_valid),
        .rise  (rx_rise),
        .fall  (unused_rx_fall)
    );

    assign accept = rx_rise & bus_active;
    assign mapped = (ptr_q <= LAST_ADDR);

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        commit   = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        wr_en    = 1'b0;
        if (bus_fall) begin
            state_d = StIdle;
            commit  = dirty_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_rise) begin
                        state_d = StWaitPtr;
                        start   = 1'b1;
                    end
                end
                StWaitPtr: begin
                    // A pointer byte overrides a coincident tx_next.
                    if (accept) begin
                        state_d  = StData;
                        ptr_load = 1'b1;
                    end else if (tx_next) begin
                        ptr_inc = 1'b1;
                    end
                end
                StData: begin
                    wr_en   = accept;
                    ptr_inc = accept | tx_next;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= 8'h00;
            dirty_q      <= 1'b0;
            addr_err_q   <= 1'b0;
            cfg_update_q <= 1'b0;
            sh_ctrl_q    <= 2'b00;
            act_ctrl_q   <= 2'b00;
            for (int k = 0; k < NUM_BANDS; k++) begin
                sh_gain_q[k]  <= GAIN_RST;
                act_gain_q[k] <= GAIN_RST;
            end
        end else begin
            state_q      <= state_d;
            cfg_update_q <= commit;
            if (ptr_load) begin
                ptr_q <= rx_data;
            end else if (ptr_inc) begin
                ptr_q <= ptr_q + 8'd1;
            end
            if (start) begin
                dirty_q    <= 1'b0;
                addr_err_q <= 1'b0;
            end
            if (wr_en) begin
                if (mapped) begin
                    dirty_q <= 1'b1;
                    if (ptr_q == ADDR_CTRL) begin
                        sh_ctrl_q <= rx_data[CTRL_BYP_BIT:CTRL_EN_BIT];
                    end
                    for (int k = 0; k < NUM_BANDS; k++) begin
                        if (ptr_q == ADDR_GAIN_BASE + 8'(k)) begin
                            sh_gain_q[k] <= rx_data;
                        end
                    end
                end else begin
                    addr_err_q <= 1'b1;
                end
            end
            if (commit) begin
                act_ctrl_q <= sh_ctrl_q;
                for (int k = 0; k < NUM_BANDS; k++) begin
                    act_gain_q[k] <= sh_gain_q[k];
                end
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (ptr_q == ADDR_CTRL) begin
            tx_data = {6'b000000, act_ctrl_q};
        end
        for (int k = 0; k < NUM_BANDS; k++) begin
            if (ptr_q == ADDR_GAIN_BASE + 8'(k)) begin
                tx_data = act_gain_q[k];
            end
        end
    end

    always_comb begin
        band_gain = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            band_gain[8*k +: 8] = act_gain_q[k];
        end
    end

    assign eq_enable  = act_ctrl_q[CTRL_EN_BIT];
    assign eq_bypass  = act_ctrl_q[CTRL_BYP_BIT];
    assign cfg_update = cfg_update_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_eq_reg_bank.sv
// Self-checking bench for eq_reg_bank: commit scoreboard plus a table of pointer reads.
module tb_eq_reg_bank;

    localparam int unsigned NB = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_active;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          tx_next;
    logic [7:0]    tx_data;
    logic          eq_enable;
    logic          eq_bypass;
    logic [8*NB-1:0] band_gain;
    logic          cfg_update;
    logic          addr_err;

    eq_reg_bank #(
        .NUM_BANDS (NB),
        .GAIN_RST  (8'h80)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_active (bus_active),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_next    (tx_next),
        .tx_data    (tx_data),
        .eq_enable  (eq_enable),
        .eq_bypass  (eq_bypass),
        .band_gain  (band_gain),
        .cfg_update (cfg_update),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*NB-1:0] gains;
        logic            en;
        logic            byp;
    } cfg_t;

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] exp;
    } rd_vec_t;

    cfg_t       sb_q[$];
    rd_vec_t    vecs[10];
    logic [7:0] model_gain [NB];
    logic       model_en, model_byp;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pushed = 0;
    int         n_pulse  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] pack_model();
        logic [8*NB-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = model_gain[k];
        return v;
    endfunction

    // Advance one cycle and sample #1 after the edge; every cfg_update pulse is scored.
    task automatic tick();
        cfg_t e;
        @(posedge clk);
        #1;
        if (cfg_update === 1'b1) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check("cfg_update_unexpected", 80'(cfg_update), 80'(0));
            end else begin
                e = sb_q.pop_front();
                check("commit_gains", 80'(band_gain), 80'(e.gains));
                check("commit_ctrl", 80'({eq_bypass, eq_enable}), 80'({e.byp, e.en}));
            end
        end
    endtask

    task automatic push_commit();
        cfg_t e;
        e.gains = pack_model();
        e.en    = model_en;
        e.byp   = model_byp;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    task automatic start_txn();
        bus_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic stop_txn();
        bus_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_tx_next();
        tx_next = 1'b1;
        tick();
        tx_next = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h03};
        vecs[1] = '{8'h01, 8'h90};
        vecs[2] = '{8'h02, 8'hA0};
        vecs[3] = '{8'h03, 8'h70};
        vecs[4] = '{8'h04, 8'h80};
        vecs[5] = '{8'h05, 8'h33};
        vecs[6] = '{8'h06, 8'h44};
        vecs[7] = '{8'h0A, 8'h55};
        vecs[8] = '{8'h0B, 8'h00};
        vecs[9] = '{8'hFF, 8'h00};

        for (int k = 0; k < NB; k++) model_gain[k] = 8'h80;
        model_en   = 1'b0;
        model_byp  = 1'b0;
        reset      = 1'b1;
        bus_active = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_next    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_band_gain", 80'(band_gain), 80'({NB{8'h80}}));
        check("rst_eq_enable", 80'(eq_enable), 80'(0));
        check("rst_eq_bypass", 80'(eq_bypass), 80'(0));
        check("rst_tx_data", 80'(tx_data), 80'(8'h00));
        check("rst_cfg_update", 80'(cfg_update), 80'(0));
        check("rst_addr_err", 80'(addr_err), 80'(0));

        // Auto-increment burst; active copy must not move before the stop edge.
        start_txn();
        send_byte(8'h01, 1);
        send_byte(8'h90, 1);
        send_byte(8'hA0, 1);
        send_byte(8'h70, 1);
        check("pre_commit_gains", 80'(band_gain), 80'({NB{8'h80}}));
        model_gain[0] = 8'h90;
        model_gain[1] = 8'hA0;
        model_gain[2] = 8'h70;
        push_commit();
        stop_txn();
        check("burst_pulses", 80'(n_pulse), 80'(1));
        check("burst_gains", 80'(band_gain), 80'(pack_model()));
        check("burst_ptr_tx", 80'(tx_data), 80'(8'h80));

        // Level-held rx_valid counts as one byte.
        start_txn();
        send_byte(8'h05, 1);
        send_byte(8'h33, 5);
        send_byte(8'h44, 1);
        model_gain[4] = 8'h33;
        model_gain[5] = 8'h44;
        push_commit();
        stop_txn();

        // Last band then an unmapped address.
        start_txn();
        send_byte(8'(NB), 1);
        send_byte(8'h55, 1);
        check("addr_err_clear_mapped", 80'(addr_err), 80'(0));
        send_byte(8'h66, 1);
        check("addr_err_set", 80'(addr_err), 80'(1));
        model_gain[NB-1] = 8'h55;
        push_commit();
        stop_txn();
        check("addr_err_sticky", 80'(addr_err), 80'(1));

        start_txn();
        check("addr_err_cleared", 80'(addr_err), 80'(0));
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        check("ctrl_pre_commit", 80'({eq_bypass, eq_enable}), 80'(2'b00));
        model_en  = 1'b1;
        model_byp = 1'b1;
        push_commit();
        stop_txn();
        check("ctrl_enable", 80'(eq_enable), 80'(1));
        check("ctrl_bypass", 80'(eq_bypass), 80'(1));

        // Pointer write, then read back in a fresh transaction with tx_next.
        start_txn();
        send_byte(8'h00, 1);
        stop_txn();
        start_txn();
        check("rd_ctrl", 80'(tx_data), 80'(8'h03));
        pulse_tx_next();
        check("rd_next1", 80'(tx_data), 80'(8'h90));
        pulse_tx_next();
        check("rd_next2", 80'(tx_data), 80'(8'hA0));
        stop_txn();
        check("rd_no_commit", 80'(n_pulse), 80'(4));

        for (int i = 0; i < 10; i++) begin
            start_txn();
            send_byte(vecs[i].ptr, 1);
            check($sformatf("vec_rd_%0d", i), 80'(tx_data), 80'(vecs[i].exp));
            stop_txn();
        end

        // tx_next outside a transaction is ignored (pointer still 0xFF).
        pulse_tx_next();
        tick();
        check("idle_tx_next", 80'(tx_data), 80'(8'h00));

        start_txn();
        send_byte(8'hFF, 1);
        pulse_tx_next();
        check("ptr_wrap", 80'(tx_data), 80'(8'h03));
        stop_txn();

        // A byte arriving after bus_active falls is dropped.
        start_txn();
        send_byte(8'h01, 1);
        send_byte(8'h11, 1);
        model_gain[0] = 8'h11;
        push_commit();
        bus_active = 1'b0;
        tick();
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        check("late_byte_gains", 80'(band_gain), 80'(pack_model()));

        // Reset mid-transaction discards shadow writes.
        start_txn();
        send_byte(8'h01, 1);
        send_byte(8'h10, 1);
        reset      = 1'b1;
        bus_active = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < NB; k++) model_gain[k] = 8'h80;
        model_en  = 1'b0;
        model_byp = 1'b0;
        check("rst_mid_gains", 80'(band_gain), 80'(pack_model()));
        start_txn();
        send_byte(8'h02, 1);
        send_byte(8'h22, 1);
        model_gain[1] = 8'h22;
        push_commit();
        stop_txn();
        check("rst_shadow_discard", 80'(band_gain), 80'(pack_model()));

        tick();
        check("sb_empty", 80'(sb_q.size()), 80'(0));
        check("pulse_count", 80'(n_pulse), 80'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
